accum_arbiter: RTL
==================

// Module: accum_arbiter
//
// PURPOSE
//   Shares one registered accumulator datapath (acc <= acc + arg) between
//   N_REQ requesters. Round-robin arbitration, valid/ready handshake per
//   requester. The winner's operand lands in a staging register; the next
//   edge adds it into the accumulator. Sits between producer blocks and the
//   shared accumulate stage, and sequences both accept and commit.
//
// PARAMETERS
//   N_REQ   4   number of requesters (2..8)
//   WIDTH   8   operand and accumulator width in bits
//
// PORTS
//   clock         in   1              single clock, all state on posedge
//   reset         in   1              synchronous, active-high
//   req_valid     in   N_REQ          per-requester operand valid
//   req_data      in   N_REQ*WIDTH    operand i in bits [i*WIDTH +: WIDTH]
//   req_ready     out  N_REQ          one-hot grant; handshake = valid & ready
//   clear         in   1              zero accumulator and overflow flag
//   acc_out       out  WIDTH          registered accumulator value
//   grant_id      out  $clog2(N_REQ)  index of the last accepted requester
//   busy          out  1              staging register holds an uncommitted add
//   acc_overflow  out  1              sticky overflow flag
//
// BEHAVIOUR
//   - One clock. Reset is synchronous and active-high.
//   - Reset values: acc_out=0, grant_id=0, busy=0, acc_overflow=0,
//     rr_ptr=0, stage empty, FSM=IDLE. req_ready is 0 while reset=1.
//   - FSM: IDLE (stage empty), ADD (stage full), CLEAR.
//       IDLE -> ADD    on handshake
//       ADD  -> ADD    on handshake in same cycle as commit (back-to-back)
//       ADD  -> IDLE   commit with no new handshake
//       any  -> CLEAR  clear=1; CLEAR -> IDLE next cycle
//   - Arbitration (combinational): scan from rr_ptr upward, mod N_REQ. The
//     first index with req_valid=1 gets req_ready=1. At most one bit is set.
//     req_ready is all-zero when no valid, when clear=1, or in CLEAR.
//   - On handshake at edge T: stage<=req_data[i], grant_id<=i,
//     rr_ptr<=(i+1) mod N_REQ. Edge T+1 commits acc_out<=acc_out+stage.
//     Throughput is 1 operand/cycle. Latency is 2 edges from handshake to
//     acc_out.
//   - Requesters hold valid and data stable until ready. The block never
//     drops a granted operand, except on clear or reset.
//   - busy = (FSM==ADD).
//   - clear has priority over commit and handshake. acc_out<=0 and
//     acc_overflow<=0. A staged, uncommitted operand is discarded. No grant
//     is issued in the clear cycle or the CLEAR cycle. rr_ptr is unchanged.
//   - Arithmetic: the sum is computed at WIDTH+1 bits. Carry-out sets
//     acc_overflow, which stays set until clear or reset.
//   - Reset mid-operation: staged operand discarded; all state goes to reset
//     values on that edge.
//
// CONFIGURATION
//   ACCUM_ARBITER_SATURATE_EN
//     defined:   on carry-out, acc_out clamps to all-ones (2^WIDTH-1) and
//                acc_overflow sets. Later adds keep acc_out at all-ones.
//     undefined: acc_out wraps mod 2^WIDTH and acc_overflow sets (sticky).
//
// TESTING
//   1 reset: valid=4'b1111 with reset=1 -> req_ready=0, acc_out=0, busy=0.
//   2 round-robin: all 4 valid, data=1,2,3,4 held for 4 cycles
//     -> grants 0,1,2,3 in order; acc_out=10 two edges after last handshake.
//   3 fairness: only req 2 valid with data=5 for 3 cycles -> three grants
//     to 2; rr_ptr=3 after each; acc_out=15.
//   4 overflow: acc=250, add 10 -> wrap build: acc_out=4, overflow=1;
//     SATURATE_EN build: acc_out=255, overflow=1.
//   5 clear race: handshake data=7 at T, clear=1 at T+1 -> acc_out=0,
//     overflow=0, busy=0; 7 is never added; no req_ready at T+1 or T+2.
//   6 mid-op reset: 3 back-to-back adds, reset at 2nd commit
//     -> all outputs 0 next cycle; grant restarts at index 0.

Source files
------------

// File: rtl/accum_arbiter.sv
// Round-robin arbiter feeding a shared staged accumulator (acc <= acc + arg).
// Define ACCUM_ARBITER_SATURATE_EN to clamp on carry-out instead of wrapping.
module accum_arbiter #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 8,
    parameter int PW    = $clog2(N_REQ)
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [N_REQ-1:0]       req_valid,
    input  logic [N_REQ*WIDTH-1:0] req_data,
    output logic [N_REQ-1:0]       req_ready,
    input  logic                   clear,
    output logic [WIDTH-1:0]       acc_out,
    output logic [PW-1:0]          grant_id,
    output logic                   busy,
    output logic                   acc_overflow
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ADD   = 2'd1;
    localparam logic [1:0] S_CLEAR = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [PW-1:0]    rr_q, rr_d;
    logic [WIDTH-1:0] stage_q, stage_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic             ovf_q, ovf_d;
    logic [PW-1:0]    gid_q, gid_d;

    logic             hs;
    logic [PW-1:0]    win;
    logic [PW-1:0]    idx;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] commit_val;

    // First valid index at or above rr_q (wrapping) wins.
    always_comb begin
        hs  = 1'b0;
        win = '0;
        idx = '0;
        if (!(reset || clear || state_q == S_CLEAR)) begin
            for (int k = 0; k < N_REQ; k++) begin
                idx = PW'((int'(rr_q) + k) % N_REQ);
                if (!hs && req_valid[idx]) begin
                    hs  = 1'b1;
                    win = idx;
                end
            end
        end
    end

    assign req_ready = hs ? (N_REQ'(1) << win) : '0;

    assign sum = {1'b0, acc_q} + {1'b0, stage_q};

`ifdef ACCUM_ARBITER_SATURATE_EN
    assign commit_val = sum[WIDTH] ? '1 : sum[WIDTH-1:0];
`else
    assign commit_val = sum[WIDTH-1:0];
`endif

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        stage_d = stage_q;
        acc_d   = acc_q;
        ovf_d   = ovf_q;
        gid_d   = gid_q;
        if (clear) begin
            state_d = S_CLEAR;
            acc_d   = '0;
            ovf_d   = 1'b0;
        end else begin
            if (state_q == S_ADD) begin
                acc_d = commit_val;
                ovf_d = ovf_q | sum[WIDTH];
            end
            if (hs) begin
                stage_d = req_data[int'(win)*WIDTH +: WIDTH];
                gid_d   = win;
                rr_d    = (win == PW'(N_REQ - 1)) ? '0 : win + 1'b1;
                state_d = S_ADD;
            end else begin
                state_d = S_IDLE;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            rr_q    <= '0;
            stage_q <= '0;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
            gid_q   <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            stage_q <= stage_d;
            acc_q   <= acc_d;
            ovf_q   <= ovf_d;
            gid_q   <= gid_d;
        end
    end

    assign acc_out      = acc_q;
    assign grant_id     = gid_q;
    assign busy         = (state_q == S_ADD);
    assign acc_overflow = ovf_q;

endmodule
